aud_seq_ctrl: RTL and testbench
===============================

AUD_SEQ_CTRL -- requirements
Module: aud_seq_ctrl

Interface
REQ-001 SHALL have parameter MAX_ADDR, default 20'd1024000, last legal SRAM word address for recording.
REQ-002 SHALL have parameter SAMPLES_PER_SEC, default 32000, LRC frames per elapsed-time second.
REQ-003 SHALL have port i_clk, in, 1, single clock; all state updates on negedge i_clk.
REQ-004 SHALL have port i_rst_n, in, 1, reset, synchronous, active-high (asserted = 1).
REQ-005 SHALL have ports i_key_rec, i_key_play, i_key_pause, i_key_stop, in, 1 each, single-cycle command pulses.
REQ-006 SHALL have port i_lrc, in, 1, codec frame clock, sampled in i_clk domain.
REQ-007 SHALL have ports i_rec_addr and i_play_addr, in, 20 each, current recorder and player word addresses.
REQ-008 SHALL have ports o_rec_start, o_rec_pause, o_rec_stop, out, 1 each, one-cycle recorder command pulses.
REQ-009 SHALL have ports o_play_start, o_play_pause, o_play_stop, out, 1 each, one-cycle player command pulses.
REQ-010 SHALL have port o_sram_sel, out, 1, SRAM owner: 0 = recorder (write), 1 = player (read).
REQ-011 SHALL have port o_sram_we_n, out, 1, SRAM write enable, active-low.
REQ-012 SHALL have port o_end_addr, out, 20, last recorded address, latched on record stop.
REQ-013 SHALL have port o_state, out, 3, encoded FSM state; o_seconds, out, 6, elapsed seconds.

Function
REQ-014 FSM states: IDLE=0, REC=1, REC_PAUSE=2, PLAY=3, PLAY_PAUSE=4, STOP=5.
REQ-015 Command priority when pulses coincide: stop > pause > play > rec; lower-priority pulses in that cycle are ignored.
REQ-016 IDLE: i_key_rec -> REC, pulse o_rec_start, clear o_seconds; i_key_play with o_end_addr != 0 -> PLAY, pulse o_play_start, clear o_seconds; i_key_play with o_end_addr == 0 ignored.
REQ-017 REC: i_key_pause -> REC_PAUSE with o_rec_pause; i_key_stop or i_rec_addr >= MAX_ADDR -> STOP, o_rec_stop pulsed, o_end_addr <= i_rec_addr.
REQ-018 REC_PAUSE: i_key_pause or i_key_rec -> REC with o_rec_start; i_key_stop -> STOP, o_rec_stop, o_end_addr <= i_rec_addr.
REQ-019 PLAY: i_key_pause -> PLAY_PAUSE with o_play_pause; i_key_stop or i_play_addr >= o_end_addr -> STOP with o_play_stop.
REQ-020 PLAY_PAUSE: i_key_pause or i_key_play -> PLAY with o_play_start; i_key_stop -> STOP with o_play_stop.
REQ-021 STOP -> IDLE unconditionally after one cycle; all command pulses ignored in STOP.
REQ-022 Every o_* pulse SHALL be registered, high exactly one cycle, in the cycle after the triggering input.
REQ-023 i_key_rec in PLAY/PLAY_PAUSE and i_key_play in REC/REC_PAUSE SHALL be ignored (no mid-operation source switch).
REQ-024 o_sram_sel = 0 in IDLE, REC, REC_PAUSE, STOP; 1 in PLAY, PLAY_PAUSE.
REQ-025 o_sram_we_n = 0 only in REC; 1 in all other states, including REC_PAUSE.
REQ-026 o_end_addr unchanged except on record stop; a new recording overwrites it.

Reset
REQ-027 While i_rst_n = 1 at a negedge i_clk: state IDLE, all pulses 0, o_sram_sel 0, o_sram_we_n 1, o_end_addr 0, o_seconds 0, internal counters 0.
REQ-028 Reset asserted mid-REC or mid-PLAY SHALL abort without emitting any stop pulse.

Configuration
REQ-029 Macro AUD_SEQ_TIMER_EN defined: falling-edge detector on i_lrc drives frame counter; in REC or PLAY, count reaching SAMPLES_PER_SEC-1 clears the counter and increments o_seconds, saturating at 63; counter frozen in pause states.
REQ-030 AUD_SEQ_TIMER_EN undefined: no frame counter or edge detector; o_seconds tied to 0.

Verification
REQ-031 Reset, then i_key_rec -> o_rec_start high one cycle, o_state=1, o_sram_we_n=0, o_sram_sel=0.
REQ-032 In REC, i_rec_addr=20'h00400, i_key_stop -> o_rec_stop one cycle, o_end_addr=20'h00400, o_state 5 then 0.
REQ-033 Then i_key_play; ramp i_play_addr to 20'h00400 -> o_play_start, o_sram_sel=1, o_play_stop when i_play_addr reaches 20'h00400.
REQ-034 In REC, i_key_pause and i_key_stop same cycle -> only o_rec_stop pulsed; i_rec_addr=1024000 alone -> auto STOP.
REQ-035 After reset, i_key_play alone -> ignored, o_state stays 0, no pulses.
REQ-036 With AUD_SEQ_TIMER_EN, SAMPLES_PER_SEC=4, 8 i_lrc falling edges in REC -> o_seconds=2; 4 edges in REC_PAUSE -> o_seconds unchanged.

Source files
------------

// File: rtl/aud_seq_ctrl.sv
// -----------------------------------------------------------------------------
// aud_seq_ctrl -- record/playback sequencer for an SRAM-backed audio recorder.
//
// Takes single-cycle key pulses and runs the recorder/player through
// IDLE/REC/REC_PAUSE/PLAY/PLAY_PAUSE/STOP. It emits one-cycle command pulses
// to the recorder and player, selects the SRAM owner and drives the SRAM
// write enable. It also latches the last recorded address so that playback
// knows where to end.
//
// All state updates happen on the falling edge of i_clk. i_rst_n is a
// synchronous, active-HIGH reset (the name is historical).
//
// Optional feature: define AUD_SEQ_TIMER_EN to build the elapsed-seconds
// timer. It counts falling edges of i_lrc while recording or playing. When
// the macro is not defined, o_seconds is tied to 0.
//
// Ports:
//   i_clk, i_rst_n                    clock (negedge active), sync reset (1 = reset)
//   i_key_rec/play/pause/stop         single-cycle command pulses
//   i_lrc                             codec frame clock (sampled on i_clk)
//   i_rec_addr, i_play_addr [19:0]    current recorder / player word address
//   o_rec_start/pause/stop            one-cycle recorder commands
//   o_play_start/pause/stop           one-cycle player commands
//   o_sram_sel                        0 = recorder owns SRAM, 1 = player
//   o_sram_we_n                       SRAM write enable, active low
//   o_end_addr [19:0]                 last recorded address
//   o_state [2:0], o_seconds [5:0]    FSM state, elapsed seconds
// -----------------------------------------------------------------------------
module aud_seq_ctrl #(
    parameter logic [19:0] MAX_ADDR        = 20'd1024000,
    parameter int          SAMPLES_PER_SEC = 32000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_key_rec,
    input  logic        i_key_play,
    input  logic        i_key_pause,
    input  logic        i_key_stop,
    input  logic        i_lrc,
    input  logic [19:0] i_rec_addr,
    input  logic [19:0] i_play_addr,
    output logic        o_rec_start,
    output logic        o_rec_pause,
    output logic        o_rec_stop,
    output logic        o_play_start,
    output logic        o_play_pause,
    output logic        o_play_stop,
    output logic        o_sram_sel,
    output logic        o_sram_we_n,
    output logic [19:0] o_end_addr,
    output logic [2:0]  o_state,
    output logic [5:0]  o_seconds
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_REC        = 3'd1;
    localparam logic [2:0] S_REC_PAUSE  = 3'd2;
    localparam logic [2:0] S_PLAY       = 3'd3;
    localparam logic [2:0] S_PLAY_PAUSE = 3'd4;
    localparam logic [2:0] S_STOP       = 3'd5;

    // Bit positions inside the registered pulse vector
    localparam int P_REC_START  = 0;
    localparam int P_REC_PAUSE  = 1;
    localparam int P_REC_STOP   = 2;
    localparam int P_PLAY_START = 3;
    localparam int P_PLAY_PAUSE = 4;
    localparam int P_PLAY_STOP  = 5;

    logic [2:0]  state_q, state_d;
    logic [5:0]  pulse_q, pulse_d;
    logic [19:0] end_addr_q, end_addr_d;
    logic        start_new;   // fresh REC/PLAY from IDLE: restart elapsed time

    // A single winning command per cycle. Lower-priority keys that arrive
    // together with a higher one are dropped, even when the winner has no
    // effect in the current state.
    logic cmd_stop, cmd_pause, cmd_play, cmd_rec;
    assign cmd_stop  = i_key_stop;
    assign cmd_pause = !i_key_stop && i_key_pause;
    assign cmd_play  = !i_key_stop && !i_key_pause && i_key_play;
    assign cmd_rec   = !i_key_stop && !i_key_pause && !i_key_play && i_key_rec;

    always_comb begin
        state_d    = state_q;
        pulse_d    = '0;
        end_addr_d = end_addr_q;
        start_new  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_rec) begin
                    state_d              = S_REC;
                    pulse_d[P_REC_START] = 1'b1;
                    start_new            = 1'b1;
                end else if (cmd_play && end_addr_q != 20'd0) begin
                    // Playback needs a finished recording to play back
                    state_d               = S_PLAY;
                    pulse_d[P_PLAY_START] = 1'b1;
                    start_new             = 1'b1;
                end
            end
            S_REC: begin
                // Running out of SRAM behaves like a stop key
                if (cmd_stop || i_rec_addr >= MAX_ADDR) begin
                    state_d             = S_STOP;
                    pulse_d[P_REC_STOP] = 1'b1;
                    end_addr_d          = i_rec_addr;
                end else if (cmd_pause) begin
                    state_d              = S_REC_PAUSE;
                    pulse_d[P_REC_PAUSE] = 1'b1;
                end
            end
            S_REC_PAUSE: begin
                if (cmd_stop) begin
                    state_d             = S_STOP;
                    pulse_d[P_REC_STOP] = 1'b1;
                    end_addr_d          = i_rec_addr;
                end else if (cmd_pause || cmd_rec) begin
                    state_d              = S_REC;
                    pulse_d[P_REC_START] = 1'b1;
                end
            end
            S_PLAY: begin
                if (cmd_stop || i_play_addr >= end_addr_q) begin
                    state_d              = S_STOP;
                    pulse_d[P_PLAY_STOP] = 1'b1;
                end else if (cmd_pause) begin
                    state_d               = S_PLAY_PAUSE;
                    pulse_d[P_PLAY_PAUSE] = 1'b1;
                end
            end
            S_PLAY_PAUSE: begin
                if (cmd_stop) begin
                    state_d              = S_STOP;
                    pulse_d[P_PLAY_STOP] = 1'b1;
                end else if (cmd_pause || cmd_play) begin
                    state_d               = S_PLAY;
                    pulse_d[P_PLAY_START] = 1'b1;
                end
            end
            S_STOP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(negedge i_clk) begin
        if (i_rst_n) begin
            state_q    <= S_IDLE;
            pulse_q    <= '0;
            end_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pulse_q    <= pulse_d;
            end_addr_q <= end_addr_d;
        end
    end

    assign o_rec_start  = pulse_q[P_REC_START];
    assign o_rec_pause  = pulse_q[P_REC_PAUSE];
    assign o_rec_stop   = pulse_q[P_REC_STOP];
    assign o_play_start = pulse_q[P_PLAY_START];
    assign o_play_pause = pulse_q[P_PLAY_PAUSE];
    assign o_play_stop  = pulse_q[P_PLAY_STOP];

    assign o_state     = state_q;
    assign o_end_addr  = end_addr_q;
    assign o_sram_sel  = (state_q == S_PLAY) || (state_q == S_PLAY_PAUSE);
    assign o_sram_we_n = (state_q != S_REC);

`ifdef AUD_SEQ_TIMER_EN
    localparam int CW = (SAMPLES_PER_SEC > 1) ? $clog2(SAMPLES_PER_SEC) : 1;

    logic          lrc_q;
    logic          lrc_fall;
    logic [CW-1:0] frame_q;
    logic [5:0]    sec_q;

    assign lrc_fall = lrc_q && !i_lrc;

    // Frames only advance while audio is actually moving. Pause states
    // freeze the count, so a resume continues the same second.
    always_ff @(negedge i_clk) begin
        if (i_rst_n) begin
            lrc_q   <= 1'b0;
            frame_q <= '0;
            sec_q   <= '0;
        end else begin
            lrc_q <= i_lrc;
            if (start_new) begin
                frame_q <= '0;
                sec_q   <= '0;
            end else if (lrc_fall && (state_q == S_REC || state_q == S_PLAY)) begin
                if (frame_q == CW'(SAMPLES_PER_SEC - 1)) begin
                    frame_q <= '0;
                    if (sec_q != 6'd63) sec_q <= sec_q + 6'd1;
                end else begin
                    frame_q <= frame_q + CW'(1);
                end
            end
        end
    end

    assign o_seconds = sec_q;
`else
    logic unused_timer;
    assign unused_timer = ^{i_lrc, start_new, (SAMPLES_PER_SEC > 0)};
    assign o_seconds    = 6'd0;
`endif

endmodule

// File: tb/tb_aud_seq_ctrl.sv
module tb_aud_seq_ctrl;

    localparam int          SPS   = 4;
    localparam logic [19:0] MAXA  = 20'd1024000;
    localparam int IDLE = 0, REC = 1, RPAU = 2, PLAY = 3, PPAU = 4, STOP = 5;

    logic        i_clk, i_rst_n;
    logic        i_key_rec, i_key_play, i_key_pause, i_key_stop, i_lrc;
    logic [19:0] i_rec_addr, i_play_addr;
    logic        o_rec_start, o_rec_pause, o_rec_stop;
    logic        o_play_start, o_play_pause, o_play_stop;
    logic        o_sram_sel, o_sram_we_n;
    logic [19:0] o_end_addr;
    logic [2:0]  o_state;
    logic [5:0]  o_seconds;

    aud_seq_ctrl #(.MAX_ADDR(MAXA), .SAMPLES_PER_SEC(SPS)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_key_rec(i_key_rec), .i_key_play(i_key_play),
        .i_key_pause(i_key_pause), .i_key_stop(i_key_stop),
        .i_lrc(i_lrc), .i_rec_addr(i_rec_addr), .i_play_addr(i_play_addr),
        .o_rec_start(o_rec_start), .o_rec_pause(o_rec_pause), .o_rec_stop(o_rec_stop),
        .o_play_start(o_play_start), .o_play_pause(o_play_pause), .o_play_stop(o_play_stop),
        .o_sram_sel(o_sram_sel), .o_sram_we_n(o_sram_we_n),
        .o_end_addr(o_end_addr), .o_state(o_state), .o_seconds(o_seconds)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the recorder described in terms of its visible
    // behaviour. Elapsed time is derived from the number of counted frames.
    int          m_st;
    logic [19:0] m_end;
    int          m_frames;
    bit          m_prev;
    bit [5:0]    m_p;   // rec_start, rec_pause, rec_stop, play_start, play_pause, play_stop

    task automatic model_step(input bit rst, rec, play, pause, stop,
                              input logic [19:0] ra, pa, input bit lrc);
        bit fall;
        int cmd;  // winning key: 0 none, 1 rec, 2 play, 3 pause, 4 stop
        m_p = '0;
        if (rst) begin
            m_st = IDLE; m_end = '0; m_frames = 0; m_prev = 1'b0;
            return;
        end
        fall   = m_prev && !lrc;
        m_prev = lrc;
        if (fall && (m_st == REC || m_st == PLAY)) m_frames++;
        cmd = stop ? 4 : pause ? 3 : play ? 2 : rec ? 1 : 0;
        case (m_st)
            IDLE: if (cmd == 1) begin m_st = REC; m_p[0] = 1; m_frames = 0; end
                  else if (cmd == 2 && m_end != 0) begin m_st = PLAY; m_p[3] = 1; m_frames = 0; end
            REC:  if (cmd == 4 || ra >= MAXA) begin m_st = STOP; m_p[2] = 1; m_end = ra; end
                  else if (cmd == 3) begin m_st = RPAU; m_p[1] = 1; end
            RPAU: if (cmd == 4) begin m_st = STOP; m_p[2] = 1; m_end = ra; end
                  else if (cmd == 3 || cmd == 1) begin m_st = REC; m_p[0] = 1; end
            PLAY: if (cmd == 4 || pa >= m_end) begin m_st = STOP; m_p[5] = 1; end
                  else if (cmd == 3) begin m_st = PPAU; m_p[4] = 1; end
            PPAU: if (cmd == 4) begin m_st = STOP; m_p[5] = 1; end
                  else if (cmd == 3 || cmd == 2) begin m_st = PLAY; m_p[3] = 1; end
            default: m_st = IDLE;
        endcase
    endtask

    function automatic int exp_seconds();
`ifdef AUD_SEQ_TIMER_EN
        return (m_frames / SPS > 63) ? 63 : m_frames / SPS;
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at posedge, DUT updates on negedge, check at next posedge.
    task automatic step(input bit rst, rec, play, pause, stop,
                        input logic [19:0] ra, pa, input bit lrc);
        logic [5:0] pv;
        i_rst_n = rst; i_key_rec = rec; i_key_play = play;
        i_key_pause = pause; i_key_stop = stop;
        i_rec_addr = ra; i_play_addr = pa; i_lrc = lrc;
        model_step(rst, rec, play, pause, stop, ra, pa, lrc);
        @(negedge i_clk);
        @(posedge i_clk);
        pv = {o_play_stop, o_play_pause, o_play_start, o_rec_stop, o_rec_pause, o_rec_start};
        chk("state",    32'(o_state),     32'(m_st));
        chk("pulses",   32'(pv),          32'(m_p));
        chk("sram_sel", 32'(o_sram_sel),  32'(m_st == PLAY || m_st == PPAU));
        chk("we_n",     32'(o_sram_we_n), 32'(m_st != REC));
        chk("end_addr", 32'(o_end_addr),  32'(m_end));
        chk("seconds",  32'(o_seconds),   32'(exp_seconds()));
    endtask

    task automatic idle_step(input logic [19:0] ra, pa);
        step(0, 0, 0, 0, 0, ra, pa, 0);
    endtask

    initial begin
        i_rst_n = 1; i_key_rec = 0; i_key_play = 0; i_key_pause = 0; i_key_stop = 0;
        i_lrc = 0; i_rec_addr = 0; i_play_addr = 0;
        @(posedge i_clk);

        // Reset
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_state", 32'(o_state), 0);
        chk("rst_we_n",  32'(o_sram_we_n), 1);
        chk("rst_end",   32'(o_end_addr), 0);

        // Play with nothing recorded is ignored
        step(0, 0, 1, 0, 0, 0, 0, 0);
        chk("play_empty_state", 32'(o_state), 0);
        chk("play_empty_start", 32'(o_play_start), 0);

        // Record start
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("rec_start", 32'(o_rec_start), 1);
        chk("rec_state", 32'(o_state), 1);
        chk("rec_we_n",  32'(o_sram_we_n), 0);
        idle_step(20'h00400, 0);
        chk("rec_start_1cyc", 32'(o_rec_start), 0);

        // Stop recording at 0x400
        step(0, 0, 0, 0, 1, 20'h00400, 0, 0);
        chk("rec_stop",   32'(o_rec_stop), 1);
        chk("end_addr",   32'(o_end_addr), 32'h400);
        chk("stop_state", 32'(o_state), 5);
        idle_step(0, 0);
        chk("idle_after_stop", 32'(o_state), 0);

        // Playback ramps up to the end address
        step(0, 0, 1, 0, 0, 0, 20'h003FD, 0);
        chk("play_start", 32'(o_play_start), 1);
        chk("play_sel",   32'(o_sram_sel), 1);
        idle_step(0, 20'h003FE);
        idle_step(0, 20'h003FF);
        chk("play_no_early_stop", 32'(o_play_stop), 0);
        idle_step(0, 20'h00400);
        chk("play_stop", 32'(o_play_stop), 1);
        idle_step(0, 0);

        // Coincident pause+stop while recording: stop wins
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 20'h00010, 0, 0);
        chk("prio_stop",  32'(o_rec_stop), 1);
        chk("prio_pause", 32'(o_rec_pause), 0);
        chk("prio_end",   32'(o_end_addr), 32'h10);
        idle_step(0, 0);

        // Full SRAM: auto stop
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle_step(20'd1000, 0);
        idle_step(MAXA, 0);
        chk("auto_stop", 32'(o_rec_stop), 1);
        chk("auto_end",  32'(o_end_addr), 32'(MAXA));
        idle_step(0, 0);

        // Elapsed time: 8 frames recording, then 4 frames paused
        step(0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1);
            step(0, 0, 0, 0, 0, 0, 0, 0);
        end
`ifdef AUD_SEQ_TIMER_EN
        chk("sec_rec", 32'(o_seconds), 2);
`else
        chk("sec_rec", 32'(o_seconds), 0);
`endif
        step(0, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1);
            step(0, 0, 0, 0, 0, 0, 0, 0);
        end
`ifdef AUD_SEQ_TIMER_EN
        chk("sec_pause", 32'(o_seconds), 2);
`else
        chk("sec_pause", 32'(o_seconds), 0);
`endif
        step(0, 0, 0, 0, 1, 20'h00200, 0, 0);
        idle_step(0, 0);

        // Reset mid-PLAY and mid-REC: no stop pulses
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_play_stop", 32'(o_play_stop), 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_rec_stop", 32'(o_rec_stop), 0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            bit rs, kr, kp, ku, ks, lr;
            logic [19:0] ra, pa;
            rs = ($urandom_range(0, 149) == 0);
            kr = ($urandom_range(0, 7) == 0);
            kp = ($urandom_range(0, 7) == 0);
            ku = ($urandom_range(0, 9) == 0);
            ks = ($urandom_range(0, 11) == 0);
            lr = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 29) == 0) ? MAXA + 20'($urandom_range(0, 100))
                                              : 20'($urandom_range(0, 4095));
            pa = 20'($urandom_range(0, 5000));
            step(rs, kr, kp, ku, ks, ra, pa, lr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
